uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte presented with the receiver's one-cycle done strobe and holds it in a circular FIFO. Bytes are offered to the consumer (CPU bus bridge or protocol parser) over a first-word-fall-through valid/ready interface. It flags overruns, since the receiver cannot be back-pressured.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH
DATA_W, 8, byte width; fixed by the UART frame format

Ports:
clk  input  1  system clock; the single clock for all logic
rst  input  1  synchronous, active-high reset
wr_data  input  DATA_W  received byte; connects to receiver data output
wr_en  input  1  one-cycle push strobe; connects to receiver done pulse
rd_data  output  DATA_W  head-of-FIFO byte; valid only while rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts head byte when rd_valid & rd_ready
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_THRESH
overrun  output  1  sticky flag: at least one byte was dropped
drop_cnt  output  8  saturating count of dropped bytes
ovr_clr  input  1  one-cycle clear of overrun and drop_cnt

Behaviour:
- Reset (rst=1 at posedge clk): wr_ptr=rd_ptr=0, count=0, rd_valid=0, full=0, almost_full=0, overrun=0, drop_cnt=0. Storage contents are not reset. rd_data is don't-care while rd_valid=0.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit; the index is the lower bits.
  - empty when pointers are equal; full when indices are equal and MSBs differ.
  - Pointers wrap naturally from DEPTH-1 to 0.
- All status outputs (count, full, almost_full, rd_valid) are registered and consistent with each other in every cycle.
- pop = rd_valid & rd_ready.
  - On pop, rd_ptr advances; next cycle, rd_data shows the next entry.
- push_ok = wr_en & (!full | pop).
  - On push_ok, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Write-to-read latency: a byte pushed in cycle N into an empty FIFO gives rd_valid=1 and rd_data=that byte in cycle N+1. There is no same-cycle bypass.
- Simultaneous events:
  - push and pop, non-empty and not full: count unchanged; both pointers advance.
  - push while full with pop in the same cycle: the push is accepted; count stays DEPTH; no overrun.
  - push while empty with rd_ready=1: the byte is stored; no pop occurs, because rd_valid was 0.
  - rd_ready=1 while empty: ignored; no pointer change.
- Overrun: wr_en & full & !pop.
  - The byte is discarded; FIFO contents and pointers are unchanged.
  - overrun <= 1; drop_cnt increments, saturating at 255.
- ovr_clr: overrun <= 0, drop_cnt <= 0.
  - If an overrun occurs in the same cycle as ovr_clr, the set wins: overrun=1, drop_cnt=1.
- No internal state machine beyond the pointer/flag registers. Order is strict FIFO. Each accepted byte is delivered exactly once.
- Reset mid-operation: all queued bytes are discarded. A wr_en in the reset cycle is ignored.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - typedef uart_byte_t as logic [UART_DATA_W-1:0]
  - the pointer-width function, for reuse by the TX FIFO
- One natural sub-module, uart_fifo_mem: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port. The same block is reused by the transmit-side FIFO.
- Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then push 0xA5 at cycle N -> rd_valid=1, rd_data=0xA5, count=1 at N+1; pop -> rd_valid=0, count=0 next cycle.
- Push 16 bytes 0x00..0x0F with rd_ready=0 -> almost_full rises when count reaches 12; full=1 at count=16; then drain 0x00..0x0F in order; empty afterwards.
- Fill to 16, push 0x55 with rd_ready=0 -> overrun=1, drop_cnt=1, count=16; head still 0x00; pulse ovr_clr -> overrun=0, drop_cnt=0.
- Fill to 16, push 0x77 and pop in the same cycle -> no overrun, count=16; after 15 more pops, 0x77 emerges as the last byte.
- Continuous push/pop for 40 bytes at one per cycle -> all 40 delivered in order, pointers wrap twice, count stays at 1; also 300 pushes while full -> drop_cnt saturates at 255.
- Assert rst with count=7 and wr_en=1 -> next cycle count=0, rd_valid=0, overrun=0; the stale bytes never appear.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type and FIFO pointer sizing helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int uart_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Write (receiver strobe) and read (valid/ready) handshake bundle for the RX FIFO.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int DATA_W = UART_DATA_W
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  // Producer/consumer side: drives bytes in, accepts head byte.
  modport master (
    output wr_data, wr_en, rd_ready,
    input  rd_data, rd_valid
  );

  // FIFO side.
  modport slave (
    input  wr_data, wr_en, rd_ready,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; shared by the RX and TX FIFOs.
module uart_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming byte at the write index.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures receiver done strobes, first-word-fall-through
// read side, registered status flags and sticky overrun / drop counter.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int DATA_W    = UART_DATA_W,
  localparam int PTR_W    = uart_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_fifo_if.slave    fifo_if,
  input  logic             ovr_clr_i,
  output logic [PTR_W-1:0] count_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             overrun_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             pop, push_ok, ovr_event;

  // Next-state for pointers and flags; all status derives from the next
  // pointer pair so count/full/almost_full/rd_valid always agree.
  always_comb begin
    pop        = rd_valid_q & fifo_if.rd_ready;
    push_ok    = fifo_if.wr_en & (~full_q | pop);
    ovr_event  = fifo_if.wr_en & full_q & ~pop;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = wr_ptr_d - rd_ptr_d;
    rd_valid_d = (wr_ptr_d != rd_ptr_d);
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    af_d       = (count_d >= PTR_W'(AF_THRESH));
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (ovr_event) begin
      // A drop in the same cycle as a clear wins and counts from zero.
      overrun_d  = 1'b1;
      if (ovr_clr_i) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (ovr_clr_i) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // State registers with synchronous reset; storage is left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      af_q       <= af_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok & ~rst),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (fifo_if.wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (fifo_if.rd_data)
  );

  assign fifo_if.rd_valid = rd_valid_q;
  assign count_o          = count_q;
  assign full_o           = full_q;
  assign almost_full_o    = af_q;
  assign overrun_o        = overrun_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: latency, fill/drain, overrun, wrap, reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovr_clr;
  logic [4:0] count;
  logic       full, almost_full, overrun;
  logic [7:0] drop_cnt;

  int vectors    = 0;
  int miscompares = 0;

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(.DEPTH(16), .AF_THRESH(12), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_if       (bus.slave),
    .ovr_clr_i     (ovr_clr),
    .count_o       (count),
    .full_o        (full),
    .almost_full_o (almost_full),
    .overrun_o     (overrun),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ovr_clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(bus.rd_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_drop", 32'(drop_cnt), 0);

    // Single byte latency and pop.
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("lat_valid", 32'(bus.rd_valid), 1);
    check("lat_data", 32'(bus.rd_data), 32'hA5);
    check("lat_count", 32'(count), 1);
    bus.rd_ready = 1'b1;
    tick();
    check("pop_valid", 32'(bus.rd_valid), 0);
    check("pop_count", 32'(count), 0);
    // rd_ready while empty is ignored.
    tick();
    check("empty_rdy_count", 32'(count), 0);
    bus.rd_ready = 1'b0;

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      check("fill_full", 32'(full), (i + 1 == 16) ? 1 : 0);
    end
    bus.wr_en = 1'b0;
    check("fill_head", 32'(bus.rd_data), 0);

    // Push while full without pop: dropped.
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_drop", 32'(drop_cnt), 1);
    check("ovr_count", 32'(count), 16);
    check("ovr_head", 32'(bus.rd_data), 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("clr_flag", 32'(overrun), 0);
    check("clr_drop", 32'(drop_cnt), 0);

    // Push 0x77 while full with simultaneous pop.
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.rd_ready = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("pp_ovr", 32'(overrun), 0);
    check("pp_count", 32'(count), 16);
    check("pp_full", 32'(full), 1);
    for (int j = 0; j < 16; j++) begin
      check("drain_valid", 32'(bus.rd_valid), 1);
      check("drain_data", 32'(bus.rd_data), (j < 15) ? 32'(j + 1) : 32'h77);
      tick();
    end
    bus.rd_ready = 1'b0;
    check("drain_empty", 32'(bus.rd_valid), 0);
    check("drain_count", 32'(count), 0);

    // Continuous streaming of 40 bytes, one per cycle.
    bus.rd_ready = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hC0;
    tick();
    for (int i = 1; i < 40; i++) begin
      check("stream_data", 32'(bus.rd_data), 32'(8'hC0 ^ 8'(i - 1)));
      check("stream_count", 32'(count), 1);
      bus.wr_data = 8'hC0 ^ 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("stream_last", 32'(bus.rd_data), 32'(8'hC0 ^ 8'd39));
    check("stream_lcount", 32'(count), 1);
    tick();
    bus.rd_ready = 1'b0;
    check("stream_end", 32'(count), 0);

    // Fill, then keep pushing to saturate the drop counter.
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 8'(8'h10 + i);
      tick();
    end
    check("sat_fill", 32'(count), 16);
    for (int i = 0; i < 254; i++) tick();
    check("sat_254", 32'(drop_cnt), 254);
    tick();
    check("sat_255", 32'(drop_cnt), 255);
    for (int i = 0; i < 45; i++) tick();
    check("sat_hold", 32'(drop_cnt), 255);
    check("sat_count", 32'(count), 16);
    check("sat_head", 32'(bus.rd_data), 32'h10);

    // Drop coincident with clear: set wins.
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0; bus.wr_en = 1'b0;
    check("setwin_flag", 32'(overrun), 1);
    check("setwin_drop", 32'(drop_cnt), 1);

    // Pop 9 to leave 7, then reset with a push pending.
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    bus.rd_ready = 1'b0;
    check("pre_rst_count", 32'(count), 7);
    check("pre_rst_head", 32'(bus.rd_data), 32'h19);
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    rst = 1'b0; bus.wr_en = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_af", 32'(almost_full), 0);
    tick();
    check("post_rst_count", 32'(count), 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    check("post_rst_data", 32'(bus.rd_data), 32'h3C);
    check("post_rst_cnt1", 32'(count), 1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("post_rst_empty", 32'(bus.rd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
